// File: rtl/frame_src_switch_pkg.sv
// Shared definitions for the frame-aligned camera source selector.
// Holds the control state encoding, the source encodings and the default
// widths used by frame_src_switch and frame_src_switch_oreg.
package frame_src_switch_pkg;

    // SYNC: hunting for a start-of-frame on the selected source.
    // PASS: forwarding the frame in progress.
    typedef enum logic {
        SYNC = 1'b0,
        PASS = 1'b1
    } state_t;

    // Source encodings match the level written to the switch PIO.
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // RGB888 pixels, 16-bit status counters.
    localparam int DEFAULT_DATA_W = 24;
    localparam int DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/frame_src_switch_oreg.sv
// One-deep registered output stage with valid/ready handshake.
// A beat is loaded only when load_ok is high, so the contents stay frozen
// while the downstream holds off (out_valid & ~out_ready).
module frame_src_switch_oreg
    import frame_src_switch_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic              load_ok
);

    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    logic              sop_p1;
    logic              eop_p1;

    // The register may take a new beat when it is empty or being drained.
    assign load_ok = ~vld_p1 | out_ready;

    // Output stage: capture a forwarded beat, otherwise retire the held beat
    // once the downstream has taken it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            sop_p1  <= 1'b0;
            eop_p1  <= 1'b0;
        end else if (load) begin
            data_p1 <= in_data;
            vld_p1  <= 1'b1;
            sop_p1  <= in_sop;
            eop_p1  <= in_eop;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
    assign out_sop   = sop_p1;
    assign out_eop   = eop_p1;

endmodule

// File: rtl/frame_src_switch.sv
// Frame-aligned selector between the raw camera stream (A) and the cleaned
// stream (B). The software switch level is registered and applied only on
// an end-of-frame transfer, after which the block re-syncs to the new
// source's start-of-frame. Non-sop beats seen while re-syncing are dropped
// and counted; forwarded frames are counted on their eop.
// Optional build macro FRAME_SRC_SWITCH_DRAIN_EN: when defined, the
// unselected source is held ready and its beats are silently discarded;
// when undefined, the unselected source is stalled (ready = 0).
module frame_src_switch
    import frame_src_switch_pkg::*;
#(
    parameter int   DATA_W    = DEFAULT_DATA_W,
    parameter int   CNT_W     = DEFAULT_CNT_W,
    parameter logic SEL_RESET = SRC_A
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_valid,
    input  logic              a_sop,
    input  logic              a_eop,
    output logic              a_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_valid,
    input  logic              b_sop,
    input  logic              b_eop,
    output logic              b_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    input  logic              out_ready,
    output logic              active_sel,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              err_pulse
);

    // Drop counter stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic              sw_q;
    logic              sel_q;

    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_sop;
    logic              sel_eop;
    logic              sel_ready;
    logic              idle_ready;
    logic              load_ok;

    logic              fwd;
    logic              drop;
    logic              eop_fwd;
    logic              sop_err;

    logic [CNT_W-1:0]  frame_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic              err_q;

`ifdef FRAME_SRC_SWITCH_DRAIN_EN
    // Unselected source keeps flowing; its beats are thrown away uncounted.
    assign idle_ready = ~reset;
`else
    // Unselected source is stalled until it becomes the selected one.
    assign idle_ready = 1'b0;
`endif

    // Route the currently selected source onto the internal beat bus.
    always_comb begin
        sel_data  = a_data;
        sel_valid = a_valid;
        sel_sop   = a_sop;
        sel_eop   = a_eop;
        if (sel_q == SRC_B) begin
            sel_data  = b_data;
            sel_valid = b_valid;
            sel_sop   = b_sop;
            sel_eop   = b_eop;
        end
    end

    // Control FSM: ready generation, forward/drop decisions and next state.
    always_comb begin
        state_nxt = state;
        sel_ready = 1'b0;
        fwd       = 1'b0;
        drop      = 1'b0;
        eop_fwd   = 1'b0;
        sop_err   = 1'b0;
        case (state)
            SYNC: begin
                // Non-sop beats are always swallowed; a sop must wait for
                // room in the output register.
                sel_ready = sel_sop ? load_ok : 1'b1;
                if (sel_valid && sel_ready) begin
                    if (sel_sop) begin
                        fwd = 1'b1;
                        if (sel_eop) begin
                            // One-beat frame: complete on arrival.
                            eop_fwd = 1'b1;
                        end else begin
                            state_nxt = PASS;
                        end
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            PASS: begin
                sel_ready = load_ok;
                if (sel_valid && sel_ready) begin
                    fwd = 1'b1;
                    // A sop inside a frame means the previous eop went
                    // missing; the beat is still forwarded as a new start.
                    if (sel_sop) begin
                        sop_err = 1'b1;
                    end
                    if (sel_eop) begin
                        eop_fwd   = 1'b1;
                        state_nxt = SYNC;
                    end
                end
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    // Ready is forced low during reset; otherwise the selected source sees
    // the FSM ready and the other source sees the idle policy.
    assign a_ready = ~reset & ((sel_q == SRC_A) ? sel_ready : idle_ready);
    assign b_ready = ~reset & ((sel_q == SRC_B) ? sel_ready : idle_ready);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Register the switch level; it is consumed only at a frame boundary,
    // so intra-frame toggles collapse to the value held on the eop cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_q <= SEL_RESET;
        end else begin
            sw_q <= sw;
        end
    end

    // Active source changes on the edge that accepts an eop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q <= SEL_RESET;
        end else if (eop_fwd) begin
            sel_q <= sw_q;
        end
    end

    // Status counters and the framing-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (eop_fwd) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (drop) begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
            end
            err_q <= sop_err;
        end
    end

    frame_src_switch_oreg #(
        .DATA_W (DATA_W)
    ) u_oreg (
        .clk       (clk),
        .reset     (reset),
        .load      (fwd),
        .in_data   (sel_data),
        .in_sop    (sel_sop),
        .in_eop    (sel_eop),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .load_ok   (load_ok)
    );

    assign active_sel  = sel_q;
    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;
    assign err_pulse   = err_q;

endmodule

// File: doc/frame_src_switch.md
# frame_src_switch

Frame-aligned source selector on the camera pixel path, directly downstream of the single-bit software switch PIO. It takes the switch level written by the processor and selects between the raw camera stream (source A) and the cleaned stream (source B). The change is applied only at a frame boundary, so a frame is never torn. It re-synchronises to the new source's start-of-frame, drives one registered pixel stream toward the video output, and reports frame and drop counts for software.

## Interface
Parameters:
- DATA_W, 24, pixel width (RGB888).
- CNT_W, 16, width of the status counters.
- SEL_RESET, 0, source selected out of reset (0 = A, 1 = B).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- sw  in  1  switch level from the PIO out_port (0 = A, 1 = B).
- a_data, b_data  in  DATA_W  source pixel data.
- a_valid, b_valid  in  1  source beat valid.
- a_sop, b_sop / a_eop, b_eop  in  1  start/end-of-frame markers, qualified by valid.
- a_ready, b_ready  out  1  source ready (combinational).
- out_data  out  DATA_W  registered output pixel.
- out_valid, out_sop, out_eop  out  1  registered output qualifiers.
- out_ready  in  1  downstream ready.
- active_sel  out  1  source currently being forwarded.
- frame_count  out  CNT_W  frames forwarded (counts eop transfers); wraps.
- drop_count  out  CNT_W  beats discarded while re-syncing; saturates at all-ones.
- err_pulse  out  1  one-cycle pulse on a framing error.

## Operation
- sw is registered into sw_q every cycle. pending = sw_q.
- "Selected" source = active_sel. Transfer on a source = valid & ready.
- Output stage is one register deep. load_ok = ~out_valid | out_ready.
- State SYNC (entered from reset):
  - selected ready = 1 for non-sop beats; these are dropped and drop_count increments.
  - selected ready = load_ok for a sop beat; that beat is loaded into the output register, then go to PASS.
- State PASS:
  - selected ready = load_ok; every beat is forwarded.
  - On an eop transfer, frame_count increments and the state goes to SYNC.
  - Same cycle as that eop: if pending != active_sel, active_sel <= pending.
- sop in PASS (missing eop): the beat is forwarded as a new frame start, err_pulse = 1, state stays PASS, frame_count unchanged.
- A beat with both sop and eop set is a one-beat frame: forwarded and counted, state stays SYNC.
- Unselected source: ready = 0 (stalled), unless the drain feature is compiled in.
- sw changes are never applied mid-frame. Multiple toggles within a frame collapse to the sw_q value sampled on the eop cycle.
- Reset mid-frame: the output beat is lost, the state returns to SYNC and waits for a fresh sop.

## Timing
- Reset values: out_valid, out_sop, out_eop, out_data, frame_count, drop_count and err_pulse are all 0. active_sel = SEL_RESET, state = SYNC. a_ready and b_ready are 0 while reset is high.
- Input-to-output latency: 1 cycle (beat accepted at edge N appears on out_* after edge N).
- Full throughput: 1 beat/cycle with out_ready held high.
- out_* are held stable while out_valid & ~out_ready.
- sw to decision: sw_q lags sw by 1 cycle. A sw change must be present at least 1 cycle before the eop transfer cycle to take effect on that boundary.
- active_sel updates on the edge that accepts the eop. The new source is first eligible the following cycle.
- err_pulse asserts on the cycle after the offending transfer, for exactly 1 cycle.

## Configuration
- FRAME_SRC_SWITCH_DRAIN_EN defined: the unselected source's ready is held at 1 and its beats are discarded without counting. Both pipelines keep running; the switch re-syncs on the next sop.
- FRAME_SRC_SWITCH_DRAIN_EN not defined: the unselected source's ready is 0, and the upstream stalls.

## Structure
- Shared package frame_src_switch_pkg holds:
  - state enum {SYNC, PASS};
  - SRC_A = 1'b0 and SRC_B = 1'b1;
  - default DATA_W and CNT_W.
- One sub-module: frame_src_switch_oreg, the one-deep output register with valid/ready, instantiated once.

## Test plan
- Reset check: hold reset 3 cycles -> all outputs 0, active_sel = 0, a_ready = b_ready = 0.
- Basic pass: sw = 0; send an A frame of 4 beats (0x10..0x13, sop on beat 0, eop on beat 3) with out_ready = 1 -> identical beats on out_* one cycle later; frame_count = 1; b_ready stays 0 (drain off).
- Switch at boundary: raise sw during beat 1 of an A frame; B sends 3 non-sop beats, then sop 0x20 -> A frame completes unaltered; active_sel = 1 after the A eop; the B non-sop beats are dropped (drop_count = 3); 0x20 is output with out_sop.
- Backpressure: drop out_ready for 3 cycles mid-frame -> out_data is held, a_ready = 0, no beat lost or duplicated.
- Framing error: sop arrives on A in PASS without a prior eop -> err_pulse for 1 cycle; the beat is forwarded with out_sop = 1; frame_count unchanged.
- Drain build: with FRAME_SRC_SWITCH_DRAIN_EN defined and sw = 0 -> b_ready = 1 every cycle; B beats never reach out_*; drop_count unchanged.
